// File: rtl/fp_to_fixed_decimator.sv
// Decimates an IEEE-754 single-precision stream by DECIM and converts each kept sample
// to rounded, saturated signed fixed-point through a two-register pipeline.
module fp_to_fixed_decimator #(
  parameter int DECIM     = 2,
  parameter int OUT_W     = 16,
  parameter int FRAC_BITS = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid_in,
  input  logic [31:0]      data_in,
  output logic             valid_out,
  output logic [OUT_W-1:0] data_out,
  output logic             sat_out,
  output logic             nan_out
);

  localparam int PH_W = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam logic [63:0] MAX_POS = (64'd1 << (OUT_W - 1)) - 64'd1;
  localparam logic [63:0] MIN_MAG = 64'd1 << (OUT_W - 1);
  localparam logic [OUT_W-1:0] MAX_OUT = {1'b0, {(OUT_W - 1){1'b1}}};
  localparam logic [OUT_W-1:0] MIN_OUT = {1'b1, {(OUT_W - 1){1'b0}}};

  typedef enum logic [1:0] {
    CLS_ZERO = 2'd0,
    CLS_NORM = 2'd1,
    CLS_INF  = 2'd2,
    CLS_NAN  = 2'd3
  } cls_t;

  logic [PH_W-1:0]   phase_r;
  logic              keep_s;
  cls_t              cls_s;
  logic signed [10:0] shift_s;

  logic              s1_valid_r;
  logic              sign_r;
  cls_t              cls_r;
  logic [23:0]       mant_r;
  logic signed [10:0] shift_r;

  logic signed [10:0] e_s;
  logic [5:0]        rs_s;
  logic [63:0]       tmp_s;
  logic [63:0]       mag_s;
  logic [63:0]       neg_s;
  logic              big_s;
  logic [OUT_W-1:0]  nxt_data_s;
  logic              nxt_sat_s;
  logic              nxt_nan_s;

  assign keep_s = valid_in && (phase_r == {PH_W{1'b0}});

  // Decimation phase: advances only on valid input samples
  always_ff @(posedge clk) begin
    if (rst) begin
      phase_r <= {PH_W{1'b0}};
    end else if (valid_in) begin
      if (phase_r == PH_W'(DECIM - 1)) begin
        phase_r <= {PH_W{1'b0}};
      end else begin
        phase_r <= phase_r + {{(PH_W - 1){1'b0}}, 1'b1};
      end
    end
  end

  // Unpack: classify the input and derive the binary-point shift
  always_comb begin
    shift_s = $signed({3'b000, data_in[30:23]}) - 11'sd127 + $signed(11'(FRAC_BITS));
    if (data_in[30:23] == 8'd0) begin
      cls_s = CLS_ZERO;
    end else if (data_in[30:23] == 8'd255) begin
      if (data_in[22:0] != 23'd0) begin
        cls_s = CLS_NAN;
      end else begin
        cls_s = CLS_INF;
      end
    end else begin
      cls_s = CLS_NORM;
    end
  end

  // Stage 1 registers
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_r <= 1'b0;
      sign_r     <= 1'b0;
      cls_r      <= CLS_ZERO;
      mant_r     <= 24'd0;
      shift_r    <= 11'sd0;
    end else begin
      s1_valid_r <= keep_s;
      if (keep_s) begin
        sign_r  <= data_in[31];
        cls_r   <= cls_s;
        mant_r  <= {1'b1, data_in[22:0]};
        shift_r <= shift_s;
      end
    end
  end

  // Align, round half away from zero, then saturate; huge shifts never wrap
  always_comb begin
    e_s        = shift_r - 11'sd23;
    rs_s       = 6'd0;
    tmp_s      = 64'd0;
    mag_s      = 64'd0;
    big_s      = 1'b0;
    nxt_data_s = {OUT_W{1'b0}};
    nxt_sat_s  = 1'b0;
    nxt_nan_s  = 1'b0;
    if (e_s >= 11'sd0) begin
      if (e_s > 11'sd40) begin
        big_s = 1'b1;
      end else begin
        mag_s = {40'd0, mant_r} << e_s[5:0];
      end
    end else begin
      if (e_s < -11'sd26) begin
        rs_s = 6'd26;
      end else begin
        rs_s = 6'(-e_s);
      end
      tmp_s = {39'd0, mant_r, 1'b0} >> rs_s;
      mag_s = (tmp_s >> 1) + {63'd0, tmp_s[0]};
    end
    neg_s = 64'd0 - mag_s;
    case (cls_r)
      CLS_ZERO: nxt_data_s = {OUT_W{1'b0}};
      CLS_NORM: begin
        if (!sign_r) begin
          if (big_s || (mag_s > MAX_POS)) begin
            nxt_data_s = MAX_OUT;
            nxt_sat_s  = 1'b1;
          end else begin
            nxt_data_s = mag_s[OUT_W-1:0];
          end
        end else begin
          if (big_s || (mag_s > MIN_MAG)) begin
            nxt_data_s = MIN_OUT;
            nxt_sat_s  = 1'b1;
          end else begin
            nxt_data_s = neg_s[OUT_W-1:0];
          end
        end
      end
      CLS_INF: begin
        nxt_data_s = sign_r ? MIN_OUT : MAX_OUT;
        nxt_sat_s  = 1'b1;
      end
      CLS_NAN: nxt_nan_s = 1'b1;
      default: nxt_data_s = {OUT_W{1'b0}};
    endcase
  end

  // Stage 2 output registers hold their value between valid pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_out <= 1'b0;
      data_out  <= {OUT_W{1'b0}};
      sat_out   <= 1'b0;
      nan_out   <= 1'b0;
    end else begin
      valid_out <= s1_valid_r;
      if (s1_valid_r) begin
        data_out <= nxt_data_s;
        sat_out  <= nxt_sat_s;
        nan_out  <= nxt_nan_s;
      end
    end
  end

endmodule
